// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//
// Serial UART receiver for an 8N1-style link driven by a 16x-oversampled baud
// tick. The asynchronous serial line is brought into the clock domain through
// a two-flop synchronizer. A four-state FSM then locates the start bit and
// samples each data bit at its centre. It evaluates the stop bit and
// delivers the assembled word with a one-cycle done strobe.
//
// Parameters:
//   DATA_BITS  - data bits per frame, received LSB first (default 8)
//   STOP_TICKS - ticks spent in the stop bit (16 = 1, 24 = 1.5, 32 = 2 bits)
//
// Ports:
//   i_clk        in   system clock
//   i_reset      in   asynchronous, active-high reset
//   i_tick       in   one-cycle strobe at 16x the baud rate
//   i_rx         in   serial line, asynchronous to i_clk, idles high
//   o_data       out  last received word, held until the next frame completes
//   o_rx_done    out  one-cycle pulse when a frame completes
//   o_frame_err  out  stop bit was sampled low on the last completed frame
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_TICKS = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_tick,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_rx_done,
  output logic                 o_frame_err
);

  // The bit counter needs at least one bit, even for a 1-bit data word.
  localparam int NW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [4:0]    S_START_MID = 5'd7;
  localparam logic [4:0]    S_BIT_END   = 5'd15;
  localparam logic [4:0]    S_STOP_END  = 5'(STOP_TICKS - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizer. Both flops reset high so that a reset does not create
  // a phantom falling edge (the line idles high).
  // ---------------------------------------------------------------------------
  logic rx_meta_reg;
  logic rx_s;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rx_meta_reg <= 1'b1;
      rx_s        <= 1'b1;
    end else begin
      rx_meta_reg <= i_rx;
      rx_s        <= rx_meta_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver state
  // ---------------------------------------------------------------------------
  state_t                 state_reg, state_next;
  logic [4:0]             s_reg, s_next;        // oversampling tick counter
  logic [NW-1:0]          n_reg, n_next;        // data bit counter
  logic [DATA_BITS-1:0]   b_reg, b_next;        // shift register
  logic [DATA_BITS-1:0]   data_reg, data_next;
  logic                   done_reg, done_next;
  logic                   ferr_reg, ferr_next;

  // New bit enters at the MSB and the word moves towards the LSB, so after
  // DATA_BITS shifts the first-received bit sits in bit 0. Built as a
  // concatenation so it also works for a 1-bit data word.
  logic [DATA_BITS:0]     shift_in;
  assign shift_in = {rx_s, b_reg};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      n_reg     <= '0;
      b_reg     <= '0;
      data_reg  <= '0;
      done_reg  <= 1'b0;
      ferr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      b_reg     <= b_next;
      data_reg  <= data_next;
      done_reg  <= done_next;
      ferr_reg  <= ferr_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Everything except the IDLE->START transition only moves
  // on a tick. The done strobe defaults low so it lasts exactly one cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    b_next     = b_reg;
    data_next  = data_reg;
    done_next  = 1'b0;
    ferr_next  = ferr_reg;

    unique case (state_reg)
      IDLE: begin
        // Start detection does not wait for a tick. A tick arriving in the
        // same cycle is not counted, because s is cleared here.
        if (!rx_s) begin
          state_next = START;
          s_next     = '0;
        end
      end

      START: begin
        if (i_tick) begin
          if (s_reg == S_START_MID) begin
            // Mid start bit: a line that is high again was only a glitch.
            if (!rx_s) begin
              state_next = DATA;
              s_next     = '0;
              n_next     = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end

      DATA: begin
        if (i_tick) begin
          if (s_reg == S_BIT_END) begin
            // 16 ticks after the previous sample point: a bit centre.
            s_next = '0;
            b_next = shift_in[DATA_BITS:1];
            if (n_reg == N_LAST) begin
              state_next = STOP;
            end else begin
              n_next = n_reg + NW'(1);
            end
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end

      STOP: begin
        if (i_tick) begin
          if (s_reg == S_STOP_END) begin
            // A bad stop bit still delivers the word and only flags it.
            data_next  = b_reg;
            ferr_next  = ~rx_s;
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign o_data      = data_reg;
  assign o_rx_done   = done_reg;
  assign o_frame_err = ferr_reg;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//
// Self-checking bench for uart_rx. Two receivers share one serial line
// generator: one with a single stop bit and one with two stop bits. A select
// routes the line to one of them, and the other sees an idle-high line.
// Frames are built bit by bit at 64 clocks per bit with a tick every 4
// clocks. Completed frames are captured on the falling clock edge and
// compared with the words, flags and tick latencies predicted from the
// frames that were sent.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       rx_line;
  logic       sel2;
  logic       rx1, rx2;
  logic [7:0] data1, data2;
  logic       done1, done2, ferr1, ferr2;

  int checks = 0;
  int errors = 0;
  int tick_count = 0;
  int div = 0;

  // Captured completions (dut1 / dut2), frame start tick stamps, expectations.
  logic [7:0] cap_data[$];
  logic       cap_ferr[$];
  int         cap_tick[$];
  logic [7:0] cap2_data[$];
  logic       cap2_ferr[$];
  int         cap2_tick[$];
  int         start_tick[$];
  logic [7:0] exp_data[$];
  logic       exp_ferr[$];

  always #5 clk = ~clk;

  assign rx1 = sel2 ? 1'b1 : rx_line;
  assign rx2 = sel2 ? rx_line : 1'b1;

  uart_rx #(.DATA_BITS(8), .STOP_TICKS(16)) dut (
    .i_clk(clk), .i_reset(rst), .i_tick(tick), .i_rx(rx1),
    .o_data(data1), .o_rx_done(done1), .o_frame_err(ferr1)
  );

  uart_rx #(.DATA_BITS(8), .STOP_TICKS(32)) dut2 (
    .i_clk(clk), .i_reset(rst), .i_tick(tick), .i_rx(rx2),
    .o_data(data2), .o_rx_done(done2), .o_frame_err(ferr2)
  );

  // Tick strobe: one clock in every four.
  initial begin
    tick = 1'b0;
    forever begin
      @(negedge clk);
      div  = (div + 1) % 4;
      tick = (div == 0);
    end
  end

  always @(posedge clk) if (tick) tick_count <= tick_count + 1;

  always @(negedge clk) begin
    if (done1) begin
      cap_data.push_back(data1);
      cap_ferr.push_back(ferr1);
      cap_tick.push_back(tick_count);
    end
    if (done2) begin
      cap2_data.push_back(data2);
      cap2_ferr.push_back(ferr2);
      cap2_tick.push_back(tick_count);
    end
  end

  task automatic clear_q();
    cap_data.delete();  cap_ferr.delete();  cap_tick.delete();
    cap2_data.delete(); cap2_ferr.delete(); cap2_tick.delete();
    start_tick.delete(); exp_data.delete(); exp_ferr.delete();
  endtask

  // Drive one frame; called at a falling edge, and returns at one.
  // A bad stop bit is held low long enough to cover the stop sample point,
  // then released so the line is high again before a false start is checked.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int nstop);
    rx_line = 1'b0;
    start_tick.push_back(tick_count);
    exp_data.push_back(d);
    exp_ferr.push_back(!stop_ok);
    repeat (64) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_line = d[i];
      repeat (64) @(negedge clk);
    end
    if (stop_ok) begin
      rx_line = 1'b1;
      repeat (64 * nstop) @(negedge clk);
    end else begin
      rx_line = 1'b0;
      repeat (40) @(negedge clk);
      rx_line = 1'b1;
      repeat (64 * nstop - 40) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_line = 1'b1; sel2 = 1'b0;
    repeat (3) @(negedge clk);
    checks += 4;
    if (data1 !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data1); end
    if (done1 !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b want 0", done1); end
    if (ferr1 !== 1'b0)  begin errors++; $display("FAIL reset_ferr: got %b want 0", ferr1); end
    if (data2 !== 8'h00) begin errors++; $display("FAIL reset_data2: got %h want 00", data2); end
    $display("reset: data=%h done=%b ferr=%b", data1, done1, ferr1);
    rst = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  // Compare dut1 captures against the frames sent since the last clear_q.
  // Latency: 152 ticks after detection, plus at most one tick that can fall
  // inside the synchronizer delay.
  task automatic test_frames(input string name);
    checks++;
    if (cap_data.size() !== exp_data.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d done pulses want %0d", name, cap_data.size(), exp_data.size());
    end else begin
      for (int i = 0; i < exp_data.size(); i++) begin
        int lat;
        lat = cap_tick[i] - start_tick[i];
        checks += 3;
        if (cap_data[i] !== exp_data[i]) begin
          errors++; $display("FAIL %s_data[%0d]: got %h want %h", name, i, cap_data[i], exp_data[i]);
        end
        if (cap_ferr[i] !== exp_ferr[i]) begin
          errors++; $display("FAIL %s_ferr[%0d]: got %b want %b", name, i, cap_ferr[i], exp_ferr[i]);
        end
        if (lat < 152 || lat > 153) begin
          errors++; $display("FAIL %s_latency[%0d]: got %0d ticks want 152..153", name, i, lat);
        end
        $display("%s frame %0d: data=%h ferr=%b latency=%0d ticks", name, i, cap_data[i], cap_ferr[i], lat);
      end
    end
    clear_q();
  endtask

  task automatic test_basic();
    clear_q();
    send_frame(8'hA5, 1'b1, 1);
    repeat (64) @(negedge clk);
    test_frames("basic");
  endtask

  task automatic test_glitch();
    clear_q();
    rx_line = 1'b0;
    repeat (16) @(negedge clk);
    rx_line = 1'b1;
    repeat (300) @(negedge clk);
    checks += 2;
    if (cap_data.size() != 0) begin errors++; $display("FAIL glitch_done: got %0d pulses want 0", cap_data.size()); end
    if (data1 !== 8'hA5) begin errors++; $display("FAIL glitch_hold: got %h want a5", data1); end
    $display("glitch: pulses=%0d data=%h", cap_data.size(), data1);
    clear_q();
    send_frame(8'h3C, 1'b1, 1);
    repeat (64) @(negedge clk);
    test_frames("after_glitch");
  endtask

  task automatic test_frame_err();
    clear_q();
    send_frame(8'h81, 1'b0, 1);
    repeat (100) @(negedge clk);
    checks++;
    if (ferr1 !== 1'b1) begin errors++; $display("FAIL ferr_held: got %b want 1", ferr1); end
    send_frame(8'h55, 1'b1, 1);
    repeat (64) @(negedge clk);
    checks++;
    if (ferr1 !== 1'b0) begin errors++; $display("FAIL ferr_cleared: got %b want 0", ferr1); end
    test_frames("frame_err");
  endtask

  task automatic test_back_to_back();
    clear_q();
    send_frame(8'h00, 1'b1, 1);
    send_frame(8'hFF, 1'b1, 1);
    send_frame(8'h7E, 1'b1, 1);
    repeat (64) @(negedge clk);
    test_frames("b2b");
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    d = 8'hC3;
    clear_q();
    rx_line = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_line = d[i];
      repeat (64) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    checks += 3;
    if (data1 !== 8'h00) begin errors++; $display("FAIL midreset_data: got %h want 00", data1); end
    if (done1 !== 1'b0)  begin errors++; $display("FAIL midreset_done: got %b want 0", done1); end
    if (ferr1 !== 1'b0)  begin errors++; $display("FAIL midreset_ferr: got %b want 0", ferr1); end
    $display("mid-frame reset: data=%h done=%b ferr=%b", data1, done1, ferr1);
    @(negedge clk);
    rx_line = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (800) @(negedge clk);
    checks++;
    if (cap_data.size() != 0) begin errors++; $display("FAIL midreset_pulse: got %0d pulses want 0", cap_data.size()); end
    clear_q();
    send_frame(8'h12, 1'b1, 1);
    repeat (64) @(negedge clk);
    test_frames("after_reset");
  endtask

  task automatic test_random();
    clear_q();
    for (int k = 0; k < 16; k++) begin
      logic [7:0] d;
      bit ok;
      d  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 3) != 0);
      send_frame(d, ok, 1);
      repeat ($urandom_range(64, 200)) @(negedge clk);
    end
    test_frames("random");
  endtask

  task automatic test_two_stop();
    int lat;
    sel2 = 1'b1;
    repeat (10) @(negedge clk);
    clear_q();
    send_frame(8'h5A, 1'b1, 2);
    repeat (64) @(negedge clk);
    checks++;
    if (cap2_data.size() != 1 || cap_data.size() != 0) begin
      errors++;
      $display("FAIL two_stop_count: got %0d/%0d pulses want 1/0", cap2_data.size(), cap_data.size());
    end else begin
      lat = cap2_tick[0] - start_tick[0];
      checks += 3;
      if (cap2_data[0] !== 8'h5A) begin errors++; $display("FAIL two_stop_data: got %h want 5a", cap2_data[0]); end
      if (cap2_ferr[0] !== 1'b0)  begin errors++; $display("FAIL two_stop_ferr: got %b want 0", cap2_ferr[0]); end
      if (lat < 168 || lat > 169) begin errors++; $display("FAIL two_stop_latency: got %0d ticks want 168..169", lat); end
      $display("two_stop frame: data=%h ferr=%b latency=%0d ticks", cap2_data[0], cap2_ferr[0], lat);
    end
    sel2 = 1'b0;
    clear_q();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_two_stop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
